// File: rtl/branch_unit.sv
// Branch resolution pipe: resolves branch/jump outcome, target,
// link address and misprediction; tags results with the ROB index.
// Ports: clk_i/rst_i (async, active-high), flush_i; rs_* request
// handshake in, rs_* result handshake out, fe_res_* training record.
// Optional macro LEN5_C_EN: compressed ISA, no misalignment port.
module branch_unit #(
  parameter int XLEN        = 64,
  parameter int ROB_IDX_LEN = 5,
  parameter int REG_IN      = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   rs_valid_i,
  output logic                   rs_ready_o,
  input  logic [2:0]             rs_branch_type_i,
  input  logic [ROB_IDX_LEN-1:0] rs_rob_idx_i,
  input  logic [XLEN-1:0]        rs_rs1_i,
  input  logic [XLEN-1:0]        rs_rs2_i,
  input  logic [XLEN-1:0]        rs_imm_i,
  input  logic [XLEN-1:0]        rs_curr_pc_i,
  input  logic [XLEN-1:0]        rs_pred_target_i,
  input  logic                   rs_pred_taken_i,
  output logic                   rs_valid_o,
  input  logic                   rs_ready_i,
  output logic [ROB_IDX_LEN-1:0] rs_rob_idx_o,
  output logic                   rs_res_mis_o,
  output logic [XLEN-1:0]        rs_link_addr_o,
`ifdef LEN5_C_EN
  // 2-byte alignment: a misaligned target cannot occur
`else
  output logic                   rs_except_raised_o,
`endif
  output logic                   fe_res_valid_o,
  output logic [XLEN-1:0]        fe_res_pc_o,
  output logic [XLEN-1:0]        fe_res_target_o,
  output logic                   fe_res_taken_o,
  output logic                   fe_res_mispredicted_o
);

  localparam logic [2:0] BEQ  = 3'd0;
  localparam logic [2:0] BNE  = 3'd1;
  localparam logic [2:0] BLT  = 3'd2;
  localparam logic [2:0] BGE  = 3'd3;
  localparam logic [2:0] BLTU = 3'd4;
  localparam logic [2:0] BGEU = 3'd5;
  localparam logic [2:0] JAL  = 3'd6;
  localparam logic [2:0] JALR = 3'd7;

  typedef struct packed {
    logic [2:0]             br_type;
    logic [ROB_IDX_LEN-1:0] rob_idx;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        pred_target;
    logic                   pred_taken;
  } req_t;

  req_t in_req;
  req_t s1_req;
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;
  logic s2_valid;

  assign in_req = '{
    br_type:     rs_branch_type_i,
    rob_idx:     rs_rob_idx_i,
    rs1:         rs_rs1_i,
    rs2:         rs_rs2_i,
    imm:         rs_imm_i,
    pc:          rs_curr_pc_i,
    pred_target: rs_pred_target_i,
    pred_taken:  rs_pred_taken_i
  };

  assign s2_adv = !s2_valid || rs_ready_i;

  // ---------------- S1: optional input register ----------------
  if (REG_IN != 0) begin : g_s1
    assign s1_adv = !s1_valid || s2_adv;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_valid <= 1'b0;
        s1_req   <= '0;
      end else if (flush_i) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= rs_valid_i;
        if (rs_valid_i) s1_req <= in_req;
      end
    end
  end else begin : g_no_s1
    assign s1_adv   = s2_adv;
    assign s1_valid = rs_valid_i;
    assign s1_req   = in_req;
  end

  assign rs_ready_o = s1_adv;

  // ---------------- resolution ----------------
  logic            eq;
  logic            lt;
  logic            ltu;
  logic            taken;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            mis;

  assign eq  = s1_req.rs1 == s1_req.rs2;
  assign lt  = $signed(s1_req.rs1) < $signed(s1_req.rs2);
  assign ltu = s1_req.rs1 < s1_req.rs2;

  always_comb begin
    taken = 1'b0;
    unique case (s1_req.br_type)
      BEQ:  taken = eq;
      BNE:  taken = !eq;
      BLT:  taken = lt;
      BGE:  taken = !lt;
      BLTU: taken = ltu;
      BGEU: taken = !ltu;
      JAL:  taken = 1'b1;
      JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign pc_plus4 = s1_req.pc + XLEN'(4);
  assign jalr_sum = s1_req.rs1 + s1_req.imm;

  always_comb begin
    target = s1_req.pc + s1_req.imm;
    if (s1_req.br_type == JALR)
      target = jalr_sum & ~XLEN'(1);
  end

  assign next_pc = taken ? target : pc_plus4;

  // Target only matters for a taken prediction
  assign mis = (taken != s1_req.pred_taken)
             | (taken & (target != s1_req.pred_target));

  // ---------------- S2: result register ----------------
  logic [ROB_IDX_LEN-1:0] s2_rob;
  logic                   s2_mis;
  logic [XLEN-1:0]        s2_link;
  logic [XLEN-1:0]        s2_pc;
  logic [XLEN-1:0]        s2_next_pc;
  logic                   s2_taken;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid   <= 1'b0;
      s2_rob     <= '0;
      s2_mis     <= 1'b0;
      s2_link    <= '0;
      s2_pc      <= '0;
      s2_next_pc <= '0;
      s2_taken   <= 1'b0;
    end else if (flush_i) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rob     <= s1_req.rob_idx;
        s2_mis     <= mis;
        s2_link    <= pc_plus4;
        s2_pc      <= s1_req.pc;
        s2_next_pc <= next_pc;
        s2_taken   <= taken;
      end
    end
  end

`ifdef LEN5_C_EN
`else
  logic s2_exc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_exc <= 1'b0;
    end else if (!flush_i && s2_adv && s1_valid) begin
      s2_exc <= taken & target[1];
    end
  end

  assign rs_except_raised_o = s2_exc;
`endif

  assign rs_valid_o            = s2_valid;
  assign rs_rob_idx_o          = s2_rob;
  assign rs_res_mis_o          = s2_mis;
  assign rs_link_addr_o        = s2_link;
  assign fe_res_valid_o        = s2_valid & rs_ready_i;
  assign fe_res_pc_o           = s2_pc;
  assign fe_res_target_o       = s2_next_pc;
  assign fe_res_taken_o        = s2_taken;
  assign fe_res_mispredicted_o = s2_mis;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit (XLEN=64, REG_IN=1).
// Each task drives one scenario and checks its own results.
module tb_branch_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        rs_valid_i;
  logic        rs_ready_o;
  logic [2:0]  br_type;
  logic [4:0]  rob_in;
  logic [63:0] rs1, rs2, imm, pc, ptgt;
  logic        ptaken;
  logic        rs_valid_o;
  logic        rs_ready_i;
  logic [4:0]  rob_out;
  logic        mis;
  logic [63:0] link;
`ifndef LEN5_C_EN
  logic        exc;
`endif
  logic        fe_valid;
  logic [63:0] fe_pc;
  logic [63:0] fe_target;
  logic        fe_taken;
  logic        fe_mis;

  int checks = 0;
  int passed = 0;

  branch_unit #(.XLEN(64), .ROB_IDX_LEN(5), .REG_IN(1)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .flush_i               (flush),
    .rs_valid_i            (rs_valid_i),
    .rs_ready_o            (rs_ready_o),
    .rs_branch_type_i      (br_type),
    .rs_rob_idx_i          (rob_in),
    .rs_rs1_i              (rs1),
    .rs_rs2_i              (rs2),
    .rs_imm_i              (imm),
    .rs_curr_pc_i          (pc),
    .rs_pred_target_i      (ptgt),
    .rs_pred_taken_i       (ptaken),
    .rs_valid_o            (rs_valid_o),
    .rs_ready_i            (rs_ready_i),
    .rs_rob_idx_o          (rob_out),
    .rs_res_mis_o          (mis),
    .rs_link_addr_o        (link),
`ifndef LEN5_C_EN
    .rs_except_raised_o    (exc),
`endif
    .fe_res_valid_o        (fe_valid),
    .fe_res_pc_o           (fe_pc),
    .fe_res_target_o       (fe_target),
    .fe_res_taken_o        (fe_taken),
    .fe_res_mispredicted_o (fe_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] t, input logic [4:0] r,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic [63:0] p,
                         input logic [63:0] pt, input logic pk);
    rs_valid_i = 1'b1;
    br_type = t; rob_in = r; rs1 = a; rs2 = b;
    imm = im; pc = p; ptgt = pt; ptaken = pk;
  endtask

  task automatic drain();
    rs_valid_i = 1'b0;
    rs_ready_i = 1'b1;
    flush = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    checks++; if (rs_valid_o !== 1'b0) $display("FAIL rst_valid got %b exp 0", rs_valid_o); else passed++;
    checks++; if (fe_valid !== 1'b0) $display("FAIL rst_fe_valid got %b exp 0", fe_valid); else passed++;
    checks++; if (rs_ready_o !== 1'b1) $display("FAIL rst_ready got %b exp 1", rs_ready_o); else passed++;
    checks++; if ({link, fe_target, fe_pc} !== '0) $display("FAIL rst_data got %h %h %h exp 0", link, fe_target, fe_pc); else passed++;
  endtask

  task automatic test_beq();
    set_req(3'd0, 5'd1, 64'h5, 64'h5, 64'h40, 64'h1000, 64'h1040, 1'b1);
    step();
    rs_valid_i = 1'b0;
    checks++; if (rs_valid_o !== 1'b0) $display("FAIL beq_early got %b exp 0", rs_valid_o); else passed++;
    step();
    checks++; if (rs_valid_o !== 1'b1) $display("FAIL beq_valid got %b exp 1", rs_valid_o); else passed++;
    checks++; if (fe_valid !== 1'b1) $display("FAIL beq_fe_valid got %b exp 1", fe_valid); else passed++;
    checks++; if (rob_out !== 5'd1) $display("FAIL beq_rob got %h exp 1", rob_out); else passed++;
    checks++; if (mis !== 1'b0) $display("FAIL beq_mis got %b exp 0", mis); else passed++;
    checks++; if (link !== 64'h1004) $display("FAIL beq_link got %h exp 1004", link); else passed++;
    checks++; if (fe_target !== 64'h1040) $display("FAIL beq_target got %h exp 1040", fe_target); else passed++;
    checks++; if (fe_taken !== 1'b1) $display("FAIL beq_taken got %b exp 1", fe_taken); else passed++;
    checks++; if (fe_pc !== 64'h1000) $display("FAIL beq_pc got %h exp 1000", fe_pc); else passed++;
    step();
    checks++; if (rs_valid_o !== 1'b0) $display("FAIL beq_once got %b exp 0", rs_valid_o); else passed++;
  endtask

  task automatic test_blt_bltu();
    set_req(3'd2, 5'd2, '1, 64'h1, 64'h100, 64'h3000, 64'h0, 1'b0);
    step();
    set_req(3'd4, 5'd3, '1, 64'h1, 64'h100, 64'h3000, 64'h0, 1'b0);
    step();
    rs_valid_i = 1'b0;
    checks++; if (rob_out !== 5'd2) $display("FAIL blt_rob got %h exp 2", rob_out); else passed++;
    checks++; if (fe_taken !== 1'b1) $display("FAIL blt_taken got %b exp 1", fe_taken); else passed++;
    checks++; if (mis !== 1'b1) $display("FAIL blt_mis got %b exp 1", mis); else passed++;
    checks++; if (fe_mis !== 1'b1) $display("FAIL blt_fe_mis got %b exp 1", fe_mis); else passed++;
    checks++; if (fe_target !== 64'h3100) $display("FAIL blt_target got %h exp 3100", fe_target); else passed++;
    step();
    checks++; if (rob_out !== 5'd3 || rs_valid_o !== 1'b1) $display("FAIL bltu_rob got %h/%b exp 3/1", rob_out, rs_valid_o); else passed++;
    checks++; if (fe_taken !== 1'b0) $display("FAIL bltu_taken got %b exp 0", fe_taken); else passed++;
    checks++; if (mis !== 1'b0) $display("FAIL bltu_mis got %b exp 0", mis); else passed++;
    checks++; if (fe_target !== 64'h3004) $display("FAIL bltu_target got %h exp 3004", fe_target); else passed++;
    drain();
  endtask

  task automatic test_conds();
    logic [5:0] exp_t;
    exp_t = 6'b100110;
    for (int k = 0; k < 6; k++) begin
      set_req(3'(k), 5'(k), '1, 64'h1, 64'h20, 64'h400, 64'h420, 1'b1);
      step();
      rs_valid_i = 1'b0;
      step();
      checks++;
      if (fe_taken !== exp_t[k] || rob_out !== 5'(k))
        $display("FAIL cond_type%0d got taken %b exp %b", k, fe_taken, exp_t[k]);
      else passed++;
    end
    drain();
  endtask

  task automatic test_jalr();
    set_req(3'd7, 5'd7, 64'h2001, 64'h0, 64'h2, 64'h5000, 64'h2002, 1'b1);
    step();
    rs_valid_i = 1'b0;
    step();
    checks++; if (fe_target !== 64'h2002) $display("FAIL jalr_target got %h exp 2002", fe_target); else passed++;
    checks++; if (mis !== 1'b0) $display("FAIL jalr_mis got %b exp 0", mis); else passed++;
    checks++; if (link !== 64'h5004) $display("FAIL jalr_link got %h exp 5004", link); else passed++;
`ifndef LEN5_C_EN
    checks++; if (exc !== 1'b1) $display("FAIL jalr_exc got %b exp 1", exc); else passed++;
`endif
    drain();
`ifndef LEN5_C_EN
    set_req(3'd6, 5'd8, 64'h0, 64'h0, 64'h8, 64'h5000, 64'h5008, 1'b1);
    step();
    rs_valid_i = 1'b0;
    step();
    checks++; if (exc !== 1'b0) $display("FAIL jal_exc got %b exp 0", exc); else passed++;
    drain();
`endif
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    logic acc;
    for (int c = 0; c < 30; c++) begin
      rs_ready_i = (c >= 5);
      if (sent < 4)
        set_req(3'd6, 5'(10 + sent), 64'h0, 64'h0, 64'h8,
                64'(256 * (sent + 1)), 64'(256 * (sent + 1) + 8), 1'b1);
      else
        rs_valid_i = 1'b0;
      #1;
      if (c < 2) begin
        checks++; if (rs_ready_o !== 1'b1) $display("FAIL b2b_ready_c%0d got %b exp 1", c, rs_ready_o); else passed++;
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (rs_ready_o !== 1'b0 || rs_valid_o !== 1'b1 || rob_out !== 5'd10)
          $display("FAIL b2b_stall_c%0d got rdy %b vld %b rob %0d exp 0 1 10", c, rs_ready_o, rs_valid_o, rob_out);
        else passed++;
      end
      if (fe_valid) begin
        checks++;
        if (rob_out !== 5'(10 + recv) || link !== 64'(256 * (recv + 1) + 4))
          $display("FAIL b2b_order got rob %0d link %h exp %0d", rob_out, link, 10 + recv);
        else passed++;
        recv++;
      end
      acc = rs_valid_i & rs_ready_o;
      @(posedge clk);
      if (acc) sent++;
      #1;
    end
    checks++; if (recv != 4) $display("FAIL b2b_count got %0d exp 4", recv); else passed++;
    drain();
  endtask

  task automatic test_flush();
    int bad = 0;
    rs_ready_i = 1'b1;
    set_req(3'd6, 5'd20, 64'h0, 64'h0, 64'h8, 64'h700, 64'h708, 1'b1);
    step();
    set_req(3'd6, 5'd21, 64'h0, 64'h0, 64'h8, 64'h710, 64'h718, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    rs_valid_i = 1'b0;
    checks++; if (rs_ready_o !== 1'b1) $display("FAIL flushA_ready got %b exp 1", rs_ready_o); else passed++;
    repeat (4) begin
      if (rs_valid_o || fe_valid) bad++;
      step();
    end
    checks++; if (bad != 0) $display("FAIL flushA_leak got %0d exp 0", bad); else passed++;

    bad = 0;
    rs_ready_i = 1'b0;
    set_req(3'd6, 5'd22, 64'h0, 64'h0, 64'h8, 64'h720, 64'h728, 1'b1);
    step();
    set_req(3'd6, 5'd23, 64'h0, 64'h0, 64'h8, 64'h730, 64'h738, 1'b1);
    step();
    set_req(3'd6, 5'd24, 64'h0, 64'h0, 64'h8, 64'h740, 64'h748, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    rs_valid_i = 1'b0;
    rs_ready_i = 1'b1;
    #1;
    checks++; if (rs_ready_o !== 1'b1) $display("FAIL flushB_ready got %b exp 1", rs_ready_o); else passed++;
    repeat (4) begin
      if (rs_valid_o || fe_valid) bad++;
      step();
    end
    checks++; if (bad != 0) $display("FAIL flushB_leak got %0d exp 0", bad); else passed++;
  endtask

  task automatic test_async_reset();
    rs_ready_i = 1'b0;
    set_req(3'd6, 5'd9, 64'h0, 64'h0, 64'h10, 64'h8000, 64'h8010, 1'b0);
    step();
    rs_valid_i = 1'b0;
    step();
    checks++; if (rs_valid_o !== 1'b1 || mis !== 1'b1) $display("FAIL ar_pre got vld %b mis %b exp 1 1", rs_valid_o, mis); else passed++;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (rs_valid_o !== 1'b0) $display("FAIL ar_valid got %b exp 0", rs_valid_o); else passed++;
    checks++;
    if ({rob_out, mis, link, fe_pc, fe_target, fe_taken, fe_mis} !== '0)
      $display("FAIL ar_data got rob %h link %h tgt %h exp 0", rob_out, link, fe_target);
    else passed++;
    checks++; if (rs_ready_o !== 1'b1) $display("FAIL ar_ready got %b exp 1", rs_ready_o); else passed++;
    @(posedge clk);
    #2;
    rst = 1'b0;
    rs_ready_i = 1'b1;
    step();
    set_req(3'd6, 5'd4, 64'h0, 64'h0, 64'h8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h4, 1'b1);
    step();
    rs_valid_i = 1'b0;
    step();
    checks++; if (rs_valid_o !== 1'b1) $display("FAIL wrap_valid got %b exp 1", rs_valid_o); else passed++;
    checks++; if (fe_target !== 64'h4) $display("FAIL wrap_target got %h exp 4", fe_target); else passed++;
    checks++; if (link !== 64'h0) $display("FAIL wrap_link got %h exp 0", link); else passed++;
    checks++; if (mis !== 1'b0) $display("FAIL wrap_mis got %b exp 0", mis); else passed++;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    rs_valid_i = 1'b0;
    rs_ready_i = 1'b1;
    br_type = '0; rob_in = '0; rs1 = '0; rs2 = '0;
    imm = '0; pc = '0; ptgt = '0; ptaken = 1'b0;
    #12;
    test_reset();
    rst = 1'b0;
    step();
    test_beq();
    test_blt_bltu();
    test_conds();
    test_jalr();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
